// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared constants and state encoding for pipeline stage registers
package pipe_stage_pkg;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pipe_stage_dffe_n.sv
// rtl/pipe_stage_dffe_n.sv - enabled register with asynchronous active-low reset
module pipe_stage_dffe_n #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline register with flush, bubble output and optional skid entry
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter int          SKID   = 1,
    parameter logic [31:0] BUBBLE = INST_NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    ps_state_e        w_state;
    ps_state_e        w_state_nxt;
    logic [1:0]       w_state_q;
    logic             w_push;
    logic             w_pop;
    logic             w_m_en;
    logic             w_s_en;
    logic [WIDTH-1:0] w_m_d;
    logic [WIDTH-1:0] w_m_q;
    logic [WIDTH-1:0] w_s_q;
    logic             w_rdy_d;
    logic             w_rdy_q;

    assign w_state   = ps_state_e'(w_state_q);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_valid = (w_state != PS_EMPTY);
    assign out_data  = out_valid ? w_m_q : BUBBLE_W;
    assign occupancy = w_state_q;

    // With SKID=1 this register is in_ready itself; with SKID=0 it only masks in_ready low until the first edge after reset.
    assign w_rdy_d  = (SKID != 0) ? (w_state_nxt != PS_FULL) : 1'b1;
    assign in_ready = (SKID != 0) ? w_rdy_q : (w_rdy_q & ((w_state == PS_EMPTY) | out_ready));

    always_comb begin
        w_state_nxt = w_state;
        w_m_en      = 1'b0;
        w_m_d       = in_data;
        w_s_en      = 1'b0;
        case (w_state)
            PS_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = PS_HALF;
                    w_m_en      = 1'b1;
                end
            end
            PS_HALF: begin
                if (w_push && w_pop) begin
                    w_m_en = 1'b1;
                end else if (w_push && (SKID != 0)) begin
                    w_state_nxt = PS_FULL;
                    w_s_en      = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (w_pop) begin
                    w_state_nxt = PS_HALF;
                    w_m_en      = 1'b1;
                    w_m_d       = w_s_q;
                end
            end
            default: w_state_nxt = PS_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = PS_EMPTY;
            w_m_en      = 1'b0;
            w_s_en      = 1'b0;
        end
    end

    pipe_stage_dffe_n #(.WIDTH(2), .RESET_VALUE(PS_EMPTY)) u_state (
        .clk(clk), .rst_n(rst), .en(1'b1), .d(w_state_nxt), .q(w_state_q)
    );

    pipe_stage_dffe_n #(.WIDTH(1), .RESET_VALUE(1'b0)) u_rdy (
        .clk(clk), .rst_n(rst), .en(1'b1), .d(w_rdy_d), .q(w_rdy_q)
    );

    pipe_stage_dffe_n #(.WIDTH(WIDTH), .RESET_VALUE(BUBBLE_W)) u_main (
        .clk(clk), .rst_n(rst), .en(w_m_en), .d(w_m_d), .q(w_m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_dffe_n #(.WIDTH(WIDTH), .RESET_VALUE(BUBBLE_W)) u_skid (
                .clk(clk), .rst_n(rst), .en(w_s_en), .d(in_data), .q(w_s_q)
            );
        end else begin : g_noskid
            assign w_s_q = BUBBLE_W;
        end
    endgenerate

endmodule
